// File: rtl/afe_pkg.sv
`default_nettype none
// ============================================================================
// afe_pkg : shared state encoding and constants for the AFE controller. Rev 1.0
// ============================================================================
package afe_pkg;

  localparam int CH_IDX_W     = 3;
  localparam int DEBOUNCE_CNT = 4;
  localparam int DEBOUNCE_TMO = 64;

  typedef enum logic [2:0] {
    RST_WAIT = 3'd0,
    IDLE     = 3'd1,
    APPLY    = 3'd2,
    SETTLE   = 3'd3,
    SAMPLE   = 3'd4
  } afe_state_t;

endpackage
`default_nettype wire

// File: rtl/afe_tick_gen.sv
`default_nettype none
// ============================================================================
// afe_tick_gen : free-running divider, 1-cycle tick at terminal count. Rev 1.0
// ============================================================================
module afe_tick_gen #(
  parameter int CLK_DIV = 25
) (
  input  logic clk_in,
  input  logic rst_in,
  output logic tick_out
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_out = (cnt_q == CW'(CLK_DIV - 1));
    cnt_d    = tick_out ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule
`default_nettype wire

// File: rtl/adc_afe_ctrl_multi.sv
`default_nettype none
// ============================================================================
// adc_afe_ctrl_multi : round-robin AFE gain/nSHDN apply + termination sample.
// Option AFE_TERM_DEBOUNCE_EN: debounced termination sample. Rev 1.0
// ============================================================================
module adc_afe_ctrl_multi
  import afe_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int GAIN_W       = 2,
  parameter int CLK_DIV      = 25,
  parameter int RST_TICKS    = 255,
  parameter int SETTLE_TICKS = 8
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [N_CH*GAIN_W-1:0] gain_in,
  input  logic [N_CH-1:0]        pwr_en_in,
  input  logic [N_CH-1:0]        term_in,
  output logic [N_CH*GAIN_W-1:0] gain_out,
  output logic [N_CH-1:0]        nshdn_out,
  output logic [N_CH-1:0]        term_state_out,
  output logic                   busy_out,
  output logic                   done_out,
  output logic [CH_IDX_W-1:0]    done_ch_out
);

  localparam int CNT_W = 16;

  logic tick;

  afe_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .tick_out (tick)
  );

  afe_state_t                state_q, state_d;
  logic [CNT_W-1:0]          wait_cnt_q, wait_cnt_d;
  logic [CH_IDX_W-1:0]       sel_q, sel_d, rr_q, rr_d, done_ch_q, done_ch_d;
  logic [N_CH*GAIN_W-1:0]    shadow_gain_q, shadow_gain_d, gain_q, gain_d;
  logic [N_CH-1:0]           shadow_pwr_q, shadow_pwr_d, valid_q, valid_d;
  logic [N_CH-1:0]           nshdn_q, nshdn_d, term_state_q, term_state_d;
  logic [N_CH-1:0]           term_meta_q, term_sync_q;
  logic                      busy_q, busy_d, done_q, done_d;
  logic [N_CH-1:0]           pending;
  logic                      found, cur_term, sample_exit;
  logic [CH_IDX_W-1:0]       pick;
`ifdef AFE_TERM_DEBOUNCE_EN
  logic [2:0]                dbc_cnt_q, dbc_cnt_d;
  logic                      dbc_last_q, dbc_last_d;
  logic [6:0]                tmo_cnt_q, tmo_cnt_d;
`endif

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    sel_d         = sel_q;
    rr_d          = rr_q;
    shadow_gain_d = shadow_gain_q;
    shadow_pwr_d  = shadow_pwr_q;
    valid_d       = valid_q;
    gain_d        = gain_q;
    nshdn_d       = nshdn_q;
    term_state_d  = term_state_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    done_ch_d     = done_ch_q;
    sample_exit   = 1'b0;
    found         = 1'b0;
    pick          = '0;
    cur_term      = 1'b0;
`ifdef AFE_TERM_DEBOUNCE_EN
    dbc_cnt_d     = dbc_cnt_q;
    dbc_last_d    = dbc_last_q;
    tmo_cnt_d     = tmo_cnt_q;
`endif

    for (int c = 0; c < N_CH; c++) begin
      pending[c] = !valid_q[c]
                 || (gain_in[c*GAIN_W +: GAIN_W] != shadow_gain_q[c*GAIN_W +: GAIN_W])
                 || (pwr_en_in[c] != shadow_pwr_q[c]);
      if (c == int'(sel_q)) cur_term = term_sync_q[c];
    end

    // First pending channel at or above the rr pointer, wrapping.
    for (int i = 0; i < N_CH; i++) begin
      for (int c = 0; c < N_CH; c++) begin
        if (!found && pending[c] && (c == (int'(rr_q) + i) % N_CH)) begin
          found = 1'b1;
          pick  = CH_IDX_W'(c);
        end
      end
    end

    if (tick) begin
      case (state_q)
        RST_WAIT: begin
          if (wait_cnt_q == CNT_W'(RST_TICKS - 1)) begin
            state_d    = IDLE;
            wait_cnt_d = '0;
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end
        IDLE: begin
          if (found) begin
            sel_d   = pick;
            state_d = APPLY;
          end
        end
        APPLY: begin
          for (int c = 0; c < N_CH; c++) begin
            if (c == int'(sel_q)) begin
              shadow_gain_d[c*GAIN_W +: GAIN_W] = gain_in[c*GAIN_W +: GAIN_W];
              gain_d[c*GAIN_W +: GAIN_W]        = gain_in[c*GAIN_W +: GAIN_W];
              shadow_pwr_d[c] = pwr_en_in[c];
              nshdn_d[c]      = pwr_en_in[c];
              valid_d[c]      = 1'b1;
            end
          end
          wait_cnt_d = '0;
          state_d    = SETTLE;
        end
        SETTLE: begin
          if (wait_cnt_q == CNT_W'(SETTLE_TICKS - 1)) begin
            state_d    = SAMPLE;
            wait_cnt_d = '0;
`ifdef AFE_TERM_DEBOUNCE_EN
            dbc_cnt_d  = '0;
            tmo_cnt_d  = '0;
`endif
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end
        SAMPLE: begin
`ifdef AFE_TERM_DEBOUNCE_EN
          dbc_cnt_d   = (dbc_cnt_q != 3'd0 && cur_term == dbc_last_q) ? dbc_cnt_q + 3'd1 : 3'd1;
          dbc_last_d  = cur_term;
          tmo_cnt_d   = tmo_cnt_q + 7'd1;
          sample_exit = (dbc_cnt_d == 3'(DEBOUNCE_CNT)) || (tmo_cnt_q == 7'(DEBOUNCE_TMO - 1));
`else
          sample_exit = 1'b1;
`endif
          if (sample_exit) begin
            for (int c = 0; c < N_CH; c++) begin
              if (c == int'(sel_q)) term_state_d[c] = cur_term;
            end
            done_d    = 1'b1;
            done_ch_d = sel_q;
            rr_d      = (int'(sel_q) == N_CH - 1) ? '0 : sel_q + 1'b1;
            state_d   = IDLE;
          end
        end
        default: begin
          state_d    = RST_WAIT;
          wait_cnt_d = '0;
        end
      endcase
      busy_d = (state_d != IDLE);
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q       <= RST_WAIT;
      wait_cnt_q    <= '0;
      sel_q         <= '0;
      rr_q          <= '0;
      shadow_gain_q <= '0;
      shadow_pwr_q  <= '0;
      valid_q       <= '0;
      gain_q        <= '0;
      nshdn_q       <= '0;
      term_state_q  <= '0;
      term_meta_q   <= '0;
      term_sync_q   <= '0;
      busy_q        <= 1'b1;
      done_q        <= 1'b0;
      done_ch_q     <= '0;
`ifdef AFE_TERM_DEBOUNCE_EN
      dbc_cnt_q     <= '0;
      dbc_last_q    <= 1'b0;
      tmo_cnt_q     <= '0;
`endif
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      sel_q         <= sel_d;
      rr_q          <= rr_d;
      shadow_gain_q <= shadow_gain_d;
      shadow_pwr_q  <= shadow_pwr_d;
      valid_q       <= valid_d;
      gain_q        <= gain_d;
      nshdn_q       <= nshdn_d;
      term_state_q  <= term_state_d;
      term_meta_q   <= term_in;
      term_sync_q   <= term_meta_q;
      busy_q        <= busy_d;
      done_q        <= done_d;
      done_ch_q     <= done_ch_d;
`ifdef AFE_TERM_DEBOUNCE_EN
      dbc_cnt_q     <= dbc_cnt_d;
      dbc_last_q    <= dbc_last_d;
      tmo_cnt_q     <= tmo_cnt_d;
`endif
    end
  end

  assign gain_out       = gain_q;
  assign nshdn_out      = nshdn_q;
  assign term_state_out = term_state_q;
  assign busy_out       = busy_q;
  assign done_out       = done_q;
  assign done_ch_out    = done_ch_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_afe_ctrl_multi.sv
`default_nettype none
// ============================================================================
// tb_adc_afe_ctrl_multi : directed scoreboard bench for adc_afe_ctrl_multi. Rev 1.0
// ============================================================================
module tb_adc_afe_ctrl_multi;

  localparam int N_CH         = 4;
  localparam int GAIN_W       = 2;
  localparam int CLK_DIV      = 25;
  localparam int RST_TICKS    = 255;
  localparam int SETTLE_TICKS = 8;
`ifdef AFE_TERM_DEBOUNCE_EN
  localparam int SAMPLE_TICKS = 4;
`else
  localparam int SAMPLE_TICKS = 1;
`endif
  // Ticks from a change being visible in IDLE to its done pulse.
  localparam int SVC = 2 + SETTLE_TICKS + SAMPLE_TICKS;

  logic                   clk_in = 1'b0;
  logic                   rst_in = 1'b1;
  logic [N_CH*GAIN_W-1:0] gain_in = '0;
  logic [N_CH-1:0]        pwr_en_in = '0;
  logic [N_CH-1:0]        term_in = '0;
  logic [N_CH*GAIN_W-1:0] gain_out;
  logic [N_CH-1:0]        nshdn_out;
  logic [N_CH-1:0]        term_state_out;
  logic                   busy_out;
  logic                   done_out;
  logic [2:0]             done_ch_out;

  typedef struct {
    int   ch;
    logic term;
    int   tick;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_cmp    = 0;
  int   n_err    = 0;
  int   tb_div   = 0;
  int   tick_cnt = 0;

  adc_afe_ctrl_multi #(
    .N_CH         (N_CH),
    .GAIN_W       (GAIN_W),
    .CLK_DIV      (CLK_DIV),
    .RST_TICKS    (RST_TICKS),
    .SETTLE_TICKS (SETTLE_TICKS)
  ) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .gain_in        (gain_in),
    .pwr_en_in      (pwr_en_in),
    .term_in        (term_in),
    .gain_out       (gain_out),
    .nshdn_out      (nshdn_out),
    .term_state_out (term_state_out),
    .busy_out       (busy_out),
    .done_out       (done_out),
    .done_ch_out    (done_ch_out)
  );

  always #5 clk_in = ~clk_in;

  // Reference tick counter: tick_cnt increments on every divided tick edge.
  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      tb_div <= 0;
    end else if (tb_div == CLK_DIV - 1) begin
      tb_div   <= 0;
      tick_cnt <= tick_cnt + 1;
    end else begin
      tb_div <= tb_div + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    int t0;
    t0 = tick_cnt;
    while (tick_cnt < t0 + n) @(negedge clk_in);
  endtask

  task automatic wait_drain(input int budget);
    int t0;
    t0 = tick_cnt;
    while (sb.size() != 0 && tick_cnt < t0 + budget) @(negedge clk_in);
    check("drain_left", 32'(sb.size()), 32'(0));
    @(negedge clk_in);
  endtask

  task automatic push(input int ch, input logic term, input int tick);
    exp_t x;
    x.ch   = ch;
    x.term = term;
    x.tick = tick;
    sb.push_back(x);
  endtask

  // Scoreboard consumer: every done pulse must match the oldest expectation.
  always @(negedge clk_in) begin
    if (done_out) begin
      check("done_expected", 32'(sb.size() != 0), 32'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("done_ch", 32'(done_ch_out), 32'(e.ch));
        check("done_term", 32'(term_state_out[e.ch]), 32'(e.term));
        check("done_tick", 32'(tick_cnt), 32'(e.tick));
      end
    end
  end

  initial begin
    int base;
    int t0;

    // Reset values
    repeat (3) @(negedge clk_in);
    check("rst_gain", 32'(gain_out), 32'(0));
    check("rst_nshdn", 32'(nshdn_out), 32'(0));
    check("rst_term", 32'(term_state_out), 32'(0));
    check("rst_busy", 32'(busy_out), 32'(1));
    check("rst_done", 32'(done_out), 32'(0));
    check("rst_done_ch", 32'(done_ch_out), 32'(0));

    // 1: defaults, every channel serviced once in order after RST_WAIT
    rst_in = 1'b0;
    base = tick_cnt;
    for (int k = 0; k < N_CH; k++) push(k, 1'b0, base + RST_TICKS + SVC * (k + 1));
    wait_ticks(100);
    check("rstwait_busy", 32'(busy_out), 32'(1));
    wait_drain(RST_TICKS + 5 * SVC);
    check("t1_busy", 32'(busy_out), 32'(0));
    check("t1_done_low", 32'(done_out), 32'(0));
    check("t1_nshdn", 32'(nshdn_out), 32'(0));
    check("t1_gain", 32'(gain_out), 32'(0));

    // 2: ch2 gain=11, power on
    gain_in   = 8'h30;
    pwr_en_in = 4'b0100;
    t0 = tick_cnt;
    push(2, 1'b0, t0 + SVC);
    wait_ticks(1);
    check("t2_gain_detect", 32'(gain_out), 32'(0));
    wait_ticks(1);
    check("t2_gain_apply", 32'(gain_out), 32'(8'h30));
    check("t2_nshdn_apply", 32'(nshdn_out), 32'(4'b0100));
    check("t2_busy", 32'(busy_out), 32'(1));
    wait_drain(2 * SVC);
    check("t2_gain_end", 32'(gain_out), 32'(8'h30));
    check("t2_nshdn_end", 32'(nshdn_out), 32'(4'b0100));

    // 3: move rr to 2 via ch1, then change ch0/ch1/ch3 together -> 3,0,1
    gain_in = 8'h34;
    t0 = tick_cnt;
    push(1, 1'b0, t0 + SVC);
    wait_drain(2 * SVC);
    gain_in   = 8'h7A;
    pwr_en_in = 4'b1101;
    t0 = tick_cnt;
    push(3, 1'b0, t0 + SVC);
    push(0, 1'b0, t0 + 2 * SVC);
    push(1, 1'b0, t0 + 3 * SVC);
    wait_drain(4 * SVC);
    check("t3_gain", 32'(gain_out), 32'(8'h7A));
    check("t3_nshdn", 32'(nshdn_out), 32'(4'b1101));

    // 4a: term_in[1]=1, glitch low during SETTLE, high again before SAMPLE
    term_in = 4'b0010;
    gain_in = 8'h7E;
    t0 = tick_cnt;
    push(1, 1'b1, t0 + SVC);
    wait_ticks(4);
    term_in = 4'b0000;
    wait_ticks(3);
    term_in = 4'b0010;
    wait_drain(2 * SVC);
    check("t4a_term", 32'(term_state_out), 32'(4'b0010));

    // 4b: ch2 powered off still samples termination; ch1 not resampled
    pwr_en_in = 4'b1001;
    term_in   = 4'b0110;
    t0 = tick_cnt;
    push(2, 1'b1, t0 + SVC);
    wait_ticks(4);
    term_in = 4'b0100;
    wait_drain(2 * SVC);
    check("t4b_term", 32'(term_state_out), 32'(4'b0110));
    check("t4b_nshdn", 32'(nshdn_out), 32'(4'b1001));

    // 5: asynchronous reset mid-SETTLE, then full re-apply
    gain_in = 8'hFE;
    wait_ticks(5);
    check("t5_pre_gain", 32'(gain_out), 32'(8'hFE));
    #2 rst_in = 1'b1;
    #1;
    check("t5_rst_gain", 32'(gain_out), 32'(0));
    check("t5_rst_nshdn", 32'(nshdn_out), 32'(0));
    check("t5_rst_term", 32'(term_state_out), 32'(0));
    check("t5_rst_busy", 32'(busy_out), 32'(1));
    check("t5_rst_done_ch", 32'(done_ch_out), 32'(0));
    @(negedge clk_in);
    rst_in = 1'b0;
    base = tick_cnt;
    for (int k = 0; k < N_CH; k++) push(k, term_in[k], base + RST_TICKS + SVC * (k + 1));
    wait_drain(RST_TICKS + 5 * SVC);
    check("t5_gain", 32'(gain_out), 32'(8'hFE));
    check("t5_nshdn", 32'(nshdn_out), 32'(4'b1001));
    check("t5_term", 32'(term_state_out), 32'(4'b0100));
    check("t5_busy", 32'(busy_out), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
